// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/ws/sd in the clk domain and delivers one
// left-justified stereo pair per frame with a single-cycle valid strobe.
module i2s_rx #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned MAX_SLOT    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ws,
  input  logic              sd,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              frame_err
);

  // Counter must hold MAX_SLOT+1 (the saturation / overrun value).
  localparam int unsigned CNT_W = $clog2(MAX_SLOT + 2);
  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_SLOT + 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LEFT,
    ST_RIGHT
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sck_d;

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  hold;
  logic [CNT_W-1:0]   cnt;
  logic               ws_last;

  logic               sck_s;
  logic               ws_s;
  logic               sd_s;
  logic               sck_rise;
  logic               boundary;
  logic [IDX_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   cnt_inc;
  logic [DATA_W-1:0]  word_c;

  // Input synchronizers plus the delayed sck copy used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= SYNC_STAGES'({sck_sync, sck});
      ws_sync  <= SYNC_STAGES'({ws_sync, ws});
      sd_sync  <= SYNC_STAGES'({sd_sync, sd});
      sck_d    <= sck_s;
    end
  end

  // Edge detect, boundary detect and the word as it stands including this edge's bit.
  always_comb begin
    sck_s    = sck_sync[SYNC_STAGES-1];
    ws_s     = ws_sync[SYNC_STAGES-1];
    sd_s     = sd_sync[SYNC_STAGES-1];
    sck_rise = sck_s & ~sck_d;
    boundary = ws_s ^ ws_last;
    cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
    bit_idx  = IDX_W'(DATA_W - 1) - IDX_W'(cnt);
    word_c   = shreg;
    if (cnt < CNT_DATA) begin
      word_c[bit_idx] = sd_s;
    end
  end

  // Framing FSM: bit capture, word commit on ws change, overrun recovery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_SYNC;
      shreg        <= '0;
      hold         <= '0;
      cnt          <= '0;
      ws_last      <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (sck_rise) begin
        if (boundary) begin
          // The bit on a ws change is the last bit of the ending word.
          shreg   <= '0;
          cnt     <= '0;
          ws_last <= ws_s;
          unique case (state)
            ST_SYNC: begin
              if (!ws_s) begin
                state <= ST_LEFT;
              end
            end
            ST_LEFT: begin
              hold  <= word_c;
              state <= ST_RIGHT;
            end
            ST_RIGHT: begin
              left_data    <= hold;
              right_data   <= word_c;
              sample_valid <= 1'b1;
              state        <= ST_LEFT;
            end
            default: begin
              state <= ST_SYNC;
            end
          endcase
        end else begin
          shreg <= word_c;
          cnt   <= cnt_inc;
          // Slot overran without a ws change: drop the frame and resync.
          if ((state != ST_SYNC) && (cnt_inc == CNT_SAT)) begin
            frame_err <= 1'b1;
            hold      <= '0;
            state     <= ST_SYNC;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: streams I2S words, predicts stereo pairs and framing
// errors from a word-level model, and checks the DUT every clk cycle.
module tb_i2s_rx;

  localparam int unsigned DATA_W      = 24;
  localparam int unsigned MAX_SLOT    = 32;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          HALF        = 4;   // clk cycles per sck phase

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sck = 1'b0;
  logic              ws  = 1'b0;
  logic              sd  = 1'b0;
  logic [DATA_W-1:0] left_data;
  logic [DATA_W-1:0] right_data;
  logic              sample_valid;
  logic              frame_err;

  i2s_rx #(
    .DATA_W      (DATA_W),
    .MAX_SLOT    (MAX_SLOT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sck          (sck),
    .ws           (ws),
    .sd           (sd),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    int          n;
    logic [63:0] bits;   // word bits left-aligned, bits[63] sent first
  } word_t;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  pair_t             exp_q[$];
  int                err_exp = 0;
  int                n_cmp   = 0;
  int                n_bad   = 0;
  int                cyc     = 0;
  int                pulse_cyc[$];
  logic [DATA_W-1:0] cur_l = '0;
  logic [DATA_W-1:0] cur_r = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic word_t mk(input logic w, input int n, input logic [63:0] v);
    word_t x;
    x.w    = w;
    x.n    = n;
    x.bits = v << (64 - n);
    return x;
  endfunction

  // Word-level prediction: a pair is emitted for each left+right word that
  // follows a 1->0 ws change while synchronized; a word running past
  // MAX_SLOT+1 bits (boundary not on bit MAX_SLOT+1) raises an error and
  // drops synchronization. The last word of a stream is never terminated.
  task automatic model_stream(input word_t wq[$], input int rst_idx);
    int                phase;
    logic [DATA_W-1:0] lval;
    logic [DATA_W-1:0] v;
    pair_t             p;
    phase = 0;
    lval  = '0;
    for (int k = 0; k + 1 < wq.size(); k++) begin
      if (k == rst_idx) phase = 0;
      v = wq[k].bits[63:64-DATA_W];
      if (phase != 0 && wq[k].n >= int'(MAX_SLOT) + 2) begin
        err_exp++;
        phase = 0;
      end
      case (phase)
        0: if (wq[k+1].w == 1'b0) phase = 1;
        1: begin lval = v; phase = 2; end
        default: begin
          p.l = lval;
          p.r = v;
          exp_q.push_back(p);
          phase = 1;
        end
      endcase
    end
  endtask

  // One sck period; op 1 pulses rst for one clk, op 2 releases rst.
  task automatic send_cell(input logic w, input logic b, input int op);
    sck = 1'b0;
    ws  = w;
    sd  = b;
    if (op == 1) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end else if (op == 2) begin
      rst = 1'b0;
    end
    repeat (HALF) begin @(posedge clk); #1; end
    sck = 1'b1;
    repeat (HALF) begin @(posedge clk); #1; end
  endtask

  // ws leads the data by one bit: it switches on the last bit of each word.
  task automatic run_stream(input word_t wq[$], input int rst_cell, input int rst_op);
    logic own_q[$];
    logic sd_q[$];
    foreach (wq[k]) begin
      for (int i = 0; i < wq[k].n; i++) begin
        own_q.push_back(wq[k].w);
        sd_q.push_back(wq[k].bits[63-i]);
      end
    end
    for (int j = 0; j < sd_q.size(); j++) begin
      send_cell((j + 1 < sd_q.size()) ? own_q[j+1] : own_q[j], sd_q[j],
                (j == rst_cell) ? rst_op : 0);
    end
  endtask

  task automatic end_test(input string name);
    repeat (8) begin @(posedge clk); #1; end
    check({name, "_pairs_left"}, 64'(exp_q.size()), 0);
    check({name, "_errs_left"}, 64'(err_exp), 0);
  endtask

  task automatic do_reset();
    sck = 1'b0; ws = 1'b0; sd = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Per-cycle compare of DUT outputs against the model's expectations.
  always @(negedge clk) begin
    pair_t p;
    cyc++;
    if (rst) begin
      cur_l = '0;
      cur_r = '0;
      check("valid_in_reset", 64'(sample_valid), 0);
      check("err_in_reset", 64'(frame_err), 0);
    end
    if (sample_valid) begin
      pulse_cyc.push_back(cyc);
      check("valid_has_pair", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        p     = exp_q.pop_front();
        cur_l = p.l;
        cur_r = p.r;
      end
    end
    if (frame_err) begin
      check("err_expected", 64'(err_exp > 0), 1);
      if (err_exp > 0) err_exp--;
    end
    check("left_data", 64'(left_data), 64'(cur_l));
    check("right_data", 64'(right_data), 64'(cur_r));
  end

  initial begin
    word_t wq[$];

    // Reset values
    repeat (3) begin @(posedge clk); #1; end
    check("rst_left", 64'(left_data), 0);
    check("rst_right", 64'(right_data), 0);
    check("rst_valid", 64'(sample_valid), 0);
    check("rst_err", 64'(frame_err), 0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // 32-bit slots
    wq = '{mk(1'b1, 8, 64'hA5), mk(1'b0, 32, 64'h12345600),
           mk(1'b1, 32, 64'hABCDEF00), mk(1'b0, 4, 64'h0)};
    model_stream(wq, -1);
    run_stream(wq, -1, 0);
    end_test("t32");
    check("t32_left_lit", 64'(left_data), 64'h123456);
    check("t32_right_lit", 64'(right_data), 64'hABCDEF);

    // 16-bit slots, zero-padded LSBs
    do_reset();
    wq = '{mk(1'b1, 16, 64'h1234), mk(1'b0, 16, 64'hBEEF),
           mk(1'b1, 16, 64'h0001), mk(1'b0, 4, 64'h0)};
    model_stream(wq, -1);
    run_stream(wq, -1, 0);
    end_test("t16");
    check("t16_left_lit", 64'(left_data), 64'hBEEF00);
    check("t16_right_lit", 64'(right_data), 64'h000100);

    // Reset released mid right word
    sck = 1'b0; ws = 1'b0; sd = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    wq = '{mk(1'b1, 24, 64'h111111), mk(1'b0, 24, 64'h222222),
           mk(1'b1, 24, 64'h333333), mk(1'b0, 4, 64'h0)};
    model_stream(wq, -1);
    run_stream(wq, 10, 2);
    end_test("trel");
    check("trel_left_lit", 64'(left_data), 64'h222222);
    check("trel_right_lit", 64'(right_data), 64'h333333);

    // Overrun in LEFT, then recovery
    do_reset();
    wq = '{mk(1'b1, 8, 64'h3C), mk(1'b0, 40, 64'h0), mk(1'b1, 24, 64'h555555),
           mk(1'b0, 24, 64'h0A0B0C), mk(1'b1, 24, 64'h0D0E0F), mk(1'b0, 4, 64'h0)};
    model_stream(wq, -1);
    run_stream(wq, -1, 0);
    end_test("tovr");
    check("tovr_left_lit", 64'(left_data), 64'h0A0B0C);
    check("tovr_right_lit", 64'(right_data), 64'h0D0E0F);

    // One-clk reset mid left word after a valid frame
    do_reset();
    wq = '{mk(1'b1, 8, 64'h81), mk(1'b0, 24, 64'h010203), mk(1'b1, 24, 64'h040506),
           mk(1'b0, 24, 64'h070809), mk(1'b1, 24, 64'h0A0A0A),
           mk(1'b0, 24, 64'h0B0B0B), mk(1'b1, 24, 64'h0C0C0C), mk(1'b0, 4, 64'h0)};
    model_stream(wq, 3);
    run_stream(wq, 8 + 24 + 24 + 12, 1);
    end_test("trst");
    check("trst_left_lit", 64'(left_data), 64'h0B0B0B);
    check("trst_right_lit", 64'(right_data), 64'h0C0C0C);

    // Three back-to-back 32-bit frames, one frame period apart
    do_reset();
    pulse_cyc.delete();
    wq = '{mk(1'b1, 8, 64'hF0),
           mk(1'b0, 32, 64'h11AA2200), mk(1'b1, 32, 64'h33BB4400),
           mk(1'b0, 32, 64'h55CC6600), mk(1'b1, 32, 64'h77DD8800),
           mk(1'b0, 32, 64'h99EEAA00), mk(1'b1, 32, 64'hBBFFCC00),
           mk(1'b0, 4, 64'h0)};
    model_stream(wq, -1);
    run_stream(wq, -1, 0);
    end_test("tb2b");
    check("tb2b_pulses", 64'(pulse_cyc.size()), 3);
    if (pulse_cyc.size() == 3) begin
      check("tb2b_gap1", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'(64 * 2 * HALF));
      check("tb2b_gap2", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'(64 * 2 * HALF));
    end
    check("tb2b_left_lit", 64'(left_data), 64'h99EEAA);
    check("tb2b_right_lit", 64'(right_data), 64'hBBFFCC);

    // 33-bit words end on the overrun bit (no error); a 34-bit word overruns
    do_reset();
    wq = '{mk(1'b1, 8, 64'h5A), mk(1'b0, 33, {31'h0, 24'hC0FFEE, 9'h1AB}),
           mk(1'b1, 33, {31'h0, 24'h5A5A5A, 9'h0F0}), mk(1'b0, 34, 64'h0),
           mk(1'b1, 24, 64'h777777), mk(1'b0, 4, 64'h0)};
    model_stream(wq, -1);
    run_stream(wq, -1, 0);
    end_test("tedge");
    check("tedge_left_lit", 64'(left_data), 64'hC0FFEE);
    check("tedge_right_lit", 64'(right_data), 64'h5A5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
